// File: rtl/bnn_request_arbiter.sv
// Round-robin front end that time-shares one combinational BNN classifier
// between several feature requesters and returns tagged predictions.
module bnn_request_arbiter #(
  parameter int FEAT_CNT      = 11,
  parameter int FEAT_BITS     = 4,
  parameter int CLASS_CNT     = 7,
  parameter int REQ_CNT       = 4,
  parameter int SETTLE_CYCLES = 2,
  localparam int PW = $clog2(CLASS_CNT),
  localparam int IW = $clog2(REQ_CNT),
  localparam int FW = FEAT_CNT * FEAT_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REQ_CNT-1:0]    req_valid,
  output logic [REQ_CNT-1:0]    req_ready,
  input  logic [REQ_CNT*FW-1:0] req_features,
  output logic [FW-1:0]         bnn_features,
  input  logic [PW-1:0]         bnn_prediction,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [PW-1:0]         res_prediction,
  output logic [IW-1:0]         res_id,
  output logic                  res_err,
  output logic                  busy
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESULT
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] id_q, id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] feat_q, feat_d;
  logic          vld_q, vld_d;
  logic [PW-1:0] pred_q, pred_d;
  logic [IW-1:0] rid_q, rid_d;
  logic          err_q, err_d;

  logic          found;
  logic [IW-1:0] gnt;
  int            idx;

  // Search starts at rr_q so the last served requester goes to the back
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int i = 0; i < REQ_CNT; i++) begin
      idx = (int'(rr_q) + i) % REQ_CNT;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      feat_q  <= '0;
      vld_q   <= 1'b0;
      pred_q  <= '0;
      rid_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      feat_q  <= feat_d;
      vld_q   <= vld_d;
      pred_q  <= pred_d;
      rid_q   <= rid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    feat_d  = feat_q;
    vld_d   = vld_q;
    pred_d  = pred_q;
    rid_d   = rid_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          feat_d  = req_features[int'(gnt)*FW +: FW];
          id_d    = gnt;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          pred_d  = bnn_prediction;
          rid_d   = id_q;
          err_d   = (int'(bnn_prediction) >= CLASS_CNT);
          vld_d   = 1'b1;
          state_d = RESULT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESULT: begin
        if (res_ready) begin
          vld_d   = 1'b0;
          rr_d    = (int'(id_q) == REQ_CNT - 1) ? '0 : id_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && found) begin
      req_ready = REQ_CNT'(1) << gnt;
    end
    busy = (state_q != IDLE);
  end

  assign bnn_features   = feat_q;
  assign res_valid      = vld_q;
  assign res_prediction = pred_q;
  assign res_id         = rid_q;
  assign res_err        = err_q;

endmodule
